// File: rtl/regfile_writeback_if.sv
// Bundle between the two result producers, the write-back block and the
// register-file write port.
//
// Handshake: a producer raises <src>_valid with <src>_rd/<src>_data stable.
// The entry is transferred at the rising edge where valid && ready are both 1.
// Payload must be held unchanged while valid && !ready. ready is derived only
// from registered FIFO occupancy, never from same-cycle valid or pop activity.
interface regfile_writeback_if #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32
);
  localparam int AW = $clog2(NUM_REGISTERS);

  logic                     alu_valid;
  logic                     alu_ready;
  logic [AW-1:0]            alu_rd;
  logic [DATA_WIDTH-1:0]    alu_data;
  logic                     ld_valid;
  logic                     ld_ready;
  logic [AW-1:0]            ld_rd;
  logic [DATA_WIDTH-1:0]    ld_data;
  logic                     write;
  logic [AW-1:0]            reg_wr;
  logic [DATA_WIDTH-1:0]    data_in;
  logic [NUM_REGISTERS-1:0] busy;

  // Write-back block side: consumes results, drives the register file.
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, write, reg_wr, data_in, busy
  );

  // Producer / environment side.
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, write, reg_wr, data_in, busy
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write-back initiator: buffers ALU and load results in small
// per-source FIFOs, round-robins them onto the single write port, and reports
// which registers have writes still pending.
// Source index 0 is the ALU, index 1 is the load unit.
module regfile_writeback #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int FIFO_DEPTH    = 2
) (
  input logic             clk,
  input logic             rst,
  regfile_writeback_if.slave bus
);
  localparam int AW = $clog2(NUM_REGISTERS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Source-indexed views of the two producer ports
  logic [1:0]            in_valid;
  logic [AW-1:0]         in_rd   [2];
  logic [DATA_WIDTH-1:0] in_data [2];

  // FIFO storage and pointers; occupancy is the pointer difference
  logic [AW-1:0]         rd_mem_q   [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [2][FIFO_DEPTH];
  logic [CW-1:0]         wptr_q [2];
  logic [CW-1:0]         wptr_d [2];
  logic [CW-1:0]         rptr_q [2];
  logic [CW-1:0]         rptr_d [2];
  logic [CW-1:0]         count  [2];
  logic [1:0]            ready;
  logic [1:0]            push;
  logic [1:0]            pop;
  logic [1:0]            nonempty;

  // Arbitration and output registers; rr_ld_q=1 means load wins a tie
  logic                     rr_ld_q, rr_ld_d;
  logic                     gsel;
  logic [AW-1:0]            head_rd;
  logic [DATA_WIDTH-1:0]    head_data;
  logic                     write_q, write_d;
  logic [AW-1:0]            reg_wr_q, reg_wr_d;
  logic [DATA_WIDTH-1:0]    data_q, data_d;
  logic [NUM_REGISTERS-1:0] busy_v;
  logic [PW-1:0]            slot;

  assign in_valid   = {bus.ld_valid, bus.alu_valid};
  assign in_rd[0]   = bus.alu_rd;
  assign in_rd[1]   = bus.ld_rd;
  assign in_data[0] = bus.alu_data;
  assign in_data[1] = bus.ld_data;

  assign bus.alu_ready = ready[0];
  assign bus.ld_ready  = ready[1];
  assign bus.write     = write_q;
  assign bus.reg_wr    = reg_wr_q;
  assign bus.data_in   = data_q;
  assign bus.busy      = busy_v;

  // Occupancy, ready (registered occupancy only, masked during reset) and push
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      count[s]    = wptr_q[s] - rptr_q[s];
      nonempty[s] = (count[s] != '0);
      ready[s]    = !rst && (count[s] < CW'(FIFO_DEPTH));
      push[s]     = in_valid[s] && ready[s];
    end
  end

  // Round-robin grant on the FIFO heads; a lone non-empty source always wins
  always_comb begin
    pop = 2'b00;
    if (nonempty[0] && nonempty[1]) begin
      if (rr_ld_q) pop[1] = 1'b1;
      else         pop[0] = 1'b1;
    end else begin
      pop = nonempty;
    end
    gsel      = pop[1];
    head_rd   = rd_mem_q[gsel][rptr_q[gsel][PW-1:0]];
    head_data = data_mem_q[gsel][rptr_q[gsel][PW-1:0]];
  end

  // Next state: pointers, tie-break pointer and the write-port registers
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      wptr_d[s] = wptr_q[s] + CW'(push[s]);
      rptr_d[s] = rptr_q[s] + CW'(pop[s]);
    end
    rr_ld_d  = rr_ld_q;
    write_d  = 1'b0;
    reg_wr_d = reg_wr_q;
    data_d   = data_q;
    if (pop[0]) rr_ld_d = 1'b1;
    if (pop[1]) rr_ld_d = 1'b0;
    if (pop != 2'b00) begin
      // x0 entries use the slot but never reach the register file
      write_d  = (head_rd != '0);
      reg_wr_d = head_rd;
      data_d   = head_data;
    end
  end

  // Pending-write vector: every live FIFO entry plus the write being driven
  always_comb begin
    busy_v = '0;
    slot   = '0;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        slot = rptr_q[s][PW-1:0] + PW'(k);
        if (CW'(k) < count[s]) busy_v[rd_mem_q[s][slot]] = 1'b1;
      end
    end
    if (write_q) busy_v[reg_wr_q] = 1'b1;
    busy_v[0] = 1'b0;
  end

  // Control state register with synchronous reset discarding queued entries
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= '0;
        rptr_q[s] <= '0;
      end
      rr_ld_q  <= 1'b1;
      write_q  <= 1'b0;
      reg_wr_q <= '0;
      data_q   <= '0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        wptr_q[s] <= wptr_d[s];
        rptr_q[s] <= rptr_d[s];
      end
      rr_ld_q  <= rr_ld_d;
      write_q  <= write_d;
      reg_wr_q <= reg_wr_d;
      data_q   <= data_d;
    end
  end

  // FIFO storage write on accepted handshakes
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (push[s]) begin
        rd_mem_q[s][wptr_q[s][PW-1:0]]   <= in_rd[s];
        data_mem_q[s][wptr_q[s][PW-1:0]] <= in_data[s];
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and random bench for regfile_writeback with a write-port scoreboard.
module tb_regfile_writeback;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  regfile_writeback_if #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR)) bus();

  regfile_writeback #(.DATA_WIDTH(DW), .NUM_REGISTERS(NR), .FIFO_DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Scoreboard state: per-source expected writes, observed log, models
  logic [AW+DW-1:0] exp_alu_q[$];
  logic [AW+DW-1:0] exp_ld_q[$];
  logic [AW-1:0]    obs_rd_q[$];
  int               obs_cyc_q[$];
  logic [DW-1:0]    rf_model [NR];
  logic [DW-1:0]    ref_mem  [NR];
  int               ld_stalls;

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_alu(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    int  waited;
    bit  ok;
    waited = 0;
    ok     = 1'b0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = rd;
    bus.alu_data  = data;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (bus.alu_ready === 1'b1) ok = 1'b1;
      else waited++;
      @(posedge clk);
    end
    #1;
    bus.alu_valid = 1'b0;
    if (!ok) check("alu_push_timeout", 64'd0, 64'd1);
    else if (rd != '0) begin
      exp_alu_q.push_back({rd, data});
      ref_mem[rd] = data;
    end
  endtask

  task automatic push_ld(input logic [AW-1:0] rd, input logic [DW-1:0] data);
    int  waited;
    bit  ok;
    waited = 0;
    ok     = 1'b0;
    bus.ld_valid = 1'b1;
    bus.ld_rd    = rd;
    bus.ld_data  = data;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (bus.ld_ready === 1'b1) ok = 1'b1;
      else begin
        waited++;
        ld_stalls++;
      end
      @(posedge clk);
    end
    #1;
    bus.ld_valid = 1'b0;
    if (!ok) check("ld_push_timeout", 64'd0, 64'd1);
    else if (rd != '0) begin
      exp_ld_q.push_back({rd, data});
      ref_mem[rd] = data;
    end
  endtask

  task automatic alu_stream(input int n);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] rd;
      int gap;
      rd = ($urandom_range(0, 15) == 0) ? '0 : AW'($urandom_range(1, 15));
      push_alu(rd, $urandom());
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic ld_stream(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      push_ld(AW'($urandom_range(16, 31)), $urandom());
      gap = $urandom_range(0, 2);
      if (gap > 0) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 0;
    while ((exp_alu_q.size() != 0 || exp_ld_q.size() != 0) && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    check(name, 64'(exp_alu_q.size() + exp_ld_q.size()), 64'd0);
  endtask

  // ---------------- monitor: match every write against a source head ----------------
  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      obs_rd_q.push_back(bus.reg_wr);
      obs_cyc_q.push_back(cyc);
      rf_model[bus.reg_wr] = bus.data_in;
      n_checks++;
      if (exp_alu_q.size() != 0 && exp_alu_q[0] === {bus.reg_wr, bus.data_in})
        void'(exp_alu_q.pop_front());
      else if (exp_ld_q.size() != 0 && exp_ld_q[0] === {bus.reg_wr, bus.data_in})
        void'(exp_ld_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL write_match: got rd=%0d data=0x%08h, no source head matches",
                 bus.reg_wr, bus.data_in);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] exp_order [4];
    n_checks  = 0;
    n_fail    = 0;
    cyc       = 0;
    ld_stalls = 0;
    for (int r = 0; r < NR; r++) begin
      rf_model[r] = '0;
      ref_mem[r]  = '0;
    end
    rst           = 1'b1;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.ld_valid  = 1'b0;
    bus.ld_rd     = '0;
    bus.ld_data   = '0;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("ready_in_rst", {bus.alu_ready, bus.ld_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_write", bus.write, 64'd0);
    check("rst_reg_wr", bus.reg_wr, 64'd0);
    check("rst_data_in", bus.data_in, 64'd0);
    check("rst_busy", bus.busy, 64'd0);
    check("ready_after_rst", {bus.alu_ready, bus.ld_ready}, 64'd3);
    @(posedge clk);
    #1;

    // Single ALU write: latency and busy window
    push_alu(5'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_write_early", bus.write, 64'd0);
    check("t1_busy_queued", bus.busy, 64'h20);
    @(negedge clk);
    check("t1_write", bus.write, 64'd1);
    check("t1_reg_wr", bus.reg_wr, 64'd5);
    check("t1_data_in", bus.data_in, 64'hDEADBEEF);
    check("t1_busy_driving", bus.busy, 64'h20);
    @(negedge clk);
    check("t1_write_done", bus.write, 64'd0);
    check("t1_busy_clear", bus.busy, 64'd0);
    @(posedge clk);
    #1;

    // Both sources, two entries each on the same edges: order 3,1,4,2 back to back
    obs_rd_q.delete();
    obs_cyc_q.delete();
    fork
      begin push_alu(5'd1, 32'hA1A1_0001); push_alu(5'd2, 32'hA2A2_0002); end
      begin push_ld(5'd3, 32'hB3B3_0003);  push_ld(5'd4, 32'hB4B4_0004);  end
    join
    repeat (6) @(negedge clk);
    exp_order[0] = 5'd3;
    exp_order[1] = 5'd1;
    exp_order[2] = 5'd4;
    exp_order[3] = 5'd2;
    check("t2_count", 64'(obs_rd_q.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < obs_rd_q.size()) begin
        check("t2_order", obs_rd_q[i], exp_order[i]);
        if (i > 0) check("t2_no_gap", 64'(obs_cyc_q[i] - obs_cyc_q[i-1]), 64'd1);
      end
    end
    @(posedge clk);
    #1;

    // Contention fills the load FIFO; held load values are accepted exactly once
    ld_stalls = 0;
    fork
      begin
        push_alu(5'd8, 32'h0000_0A08); push_alu(5'd9, 32'h0000_0A09);
        push_alu(5'd10, 32'h0000_0A0A); push_alu(5'd11, 32'h0000_0A0B);
      end
      begin
        push_ld(5'd12, 32'h0000_0B0C); push_ld(5'd13, 32'h0000_0B0D);
        push_ld(5'd14, 32'h0000_0B0E); push_ld(5'd15, 32'h0000_0B0F);
      end
    join
    wait_drain("t3_drain");
    check("t3_ld_backpressure", 64'(ld_stalls > 0), 64'd1);
    @(posedge clk);
    #1;

    // Writes to x0 are consumed silently
    obs_rd_q.delete();
    push_alu(5'd0, 32'h12345678);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_x0_write", bus.write, 64'd0);
      check("t4_x0_busy", bus.busy, 64'd0);
    end
    @(posedge clk);
    #1;

    // Reset with both FIFOs holding entries discards them
    fork
      begin push_alu(5'd20, 32'hC0DE_0020); push_alu(5'd21, 32'hC0DE_0021); end
      begin push_ld(5'd22, 32'hC0DE_0022);  push_ld(5'd23, 32'hC0DE_0023);  end
    join
    rst = 1'b1;
    @(negedge clk);
    check("t5_ready_in_rst", {bus.alu_ready, bus.ld_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    exp_alu_q.delete();
    exp_ld_q.delete();
    obs_rd_q.delete();
    @(negedge clk);
    check("t5_write_after_rst", bus.write, 64'd0);
    check("t5_busy_after_rst", bus.busy, 64'd0);
    check("t5_ready_after_rst", {bus.alu_ready, bus.ld_ready}, 64'd3);
    repeat (5) @(negedge clk);
    check("t5_no_stale_write", 64'(obs_rd_q.size()), 64'd0);
    @(posedge clk);
    #1;

    // After reset the load source wins the first tie
    fork
      push_alu(5'd6, 32'h0000_0006);
      push_ld(5'd7, 32'h0000_0007);
    join
    wait_drain("t5_tie_drain");
    check("t5_tie_count", 64'(obs_rd_q.size()), 64'd2);
    if (obs_rd_q.size() != 0) check("t5_tie_first", obs_rd_q[0], 64'd7);
    @(posedge clk);
    #1;

    // Random streams from both sources with stalls, then compare register files
    for (int r = 0; r < NR; r++) begin
      rf_model[r] = '0;
      ref_mem[r]  = '0;
    end
    fork
      alu_stream(200);
      ld_stream(200);
    join
    wait_drain("t6_drain");
    repeat (2) @(negedge clk);
    check("t6_busy_idle", bus.busy, 64'd0);
    for (int r = 0; r < NR; r++) check("t6_regfile", rf_model[r], ref_mem[r]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side initiator for the CPU register file.
- Accepts retiring results from two producers, the ALU and the load unit, through valid/ready handshakes, and buffers them in per-source FIFOs.
- Arbitrates the single register-file write port and drives write/reg_wr/data_in.
- Exports a per-register busy vector so issue logic can stall on pending writes.

Parameters:
- DATA_WIDTH, 32, width of result data and data_in.
- NUM_REGISTERS, 32, number of architectural registers; address width is clog2(NUM_REGISTERS).
- FIFO_DEPTH, 2, entries per source FIFO; must be a power of two and at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU result present.
- alu_ready  out  1  ALU FIFO can accept an entry.
- alu_rd  in  clog2(NUM_REGISTERS)  ALU destination register.
- alu_data  in  DATA_WIDTH  ALU result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load FIFO can accept an entry.
- ld_rd  in  clog2(NUM_REGISTERS)  load destination register.
- ld_data  in  DATA_WIDTH  load result.
- write  out  1  register-file write enable.
- reg_wr  out  clog2(NUM_REGISTERS)  register-file write address.
- data_in  out  DATA_WIDTH  register-file write data.
- busy  out  NUM_REGISTERS  bit r is high while a write to register r is queued or being driven.

Behaviour:
- Reset (rst high at a rising edge):
  - Both FIFOs are emptied; any in-flight entries are discarded, including during reset mid-operation.
  - write=0, reg_wr=0, data_in=0, busy=0.
  - The round-robin pointer favours the load source.
  - alu_ready and ld_ready are 0 while rst is high.
- Handshake:
  - An entry is pushed at a rising edge when valid && ready.
  - ready is a registered function of the FIFO count: ready = (count < FIFO_DEPTH). It does not depend combinationally on a same-cycle pop.
  - A full FIFO deasserts ready even if it pops in that cycle.
  - Each source's rd/data must be held while valid && !ready.
- Arbitration (combinational on the FIFO heads; the pop and the output load are registered):
  - Only one source non-empty: that source is granted.
  - Both non-empty: grant the source not granted most recently; the pointer toggles on every grant.
  - The granted head pops at the edge, and the output registers load write, reg_wr=head.rd and data_in=head.data.
  - No grant: write=0 for the next cycle; reg_wr and data_in hold their previous values.
- Register x0:
  - A granted entry with rd==0 is popped and consumes its grant slot, but write=0 for that cycle.
  - Such an entry still toggles the round-robin pointer.
- Latency: an entry pushed at edge N with an empty output path drives write=1 during the cycle after edge N+1; the register file commits it at edge N+2.
- Throughput: one write per cycle sustained whenever either FIFO is non-empty.
- Ordering:
  - FIFO order is preserved within a source.
  - No ordering is guaranteed between sources. Issue logic must not issue a second writer to rd while busy[rd]=1.
- busy:
  - Combinational OR over all valid FIFO entries of both sources, plus the output register while write=1.
  - busy[0] is always 0.
  - Simultaneous push to FIFO A and pop from FIFO B with the same rd: busy stays set.
- Simultaneous push and pop on one FIFO (not full): count is unchanged and the entries are ordered correctly.
- Counters and pointers are clog2(FIFO_DEPTH)+1 bits wide, with wrap-around on read/write pointers.

Test Plan:
- Reset, then one ALU push (rd=5, data=0xDEADBEEF) at edge 2 -> write=1, reg_wr=5, data_in=0xDEADBEEF during cycle after edge 3; busy[5]=1 from after edge 2 through the write cycle, then 0.
- ALU and load each push 2 entries (ALU rd 1,2; load rd 3,4) on the same edges -> write order 3,1,4,2 with write=1 for four consecutive cycles, no gaps.
- Hold ld_valid=1 with no drain possible until the FIFO is full (FIFO_DEPTH=2) -> ld_ready=0 after the 2nd push; a third value held stable is accepted exactly once after a pop, with no loss or duplication.
- Push ALU rd=0 data=0x12345678 -> entry consumed, write stays 0 for the whole test, busy stays 0.
- Load 2 entries into each FIFO, assert rst for one edge -> write=0 and busy=0 after that edge, ready=0 during rst and 1 after; no queued write ever appears.
- Random stream of 200 pushes per source with random valid/stall -> a scoreboard model of the register file matches a reference memory after drain, and per-source order is preserved.
